// File: rtl/lsu_if.sv
// lsu_if: core-side request/response and data_mem-side bus of the load-store unit
interface lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
    output core_rd_o, core_stall_o, core_fault_o, mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
    input  core_rd_o, core_stall_o, core_fault_o, mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/lsu.sv
// lsu: RISC-V load/store to word-wide data_mem, sub-word stores via read-modify-write
// Optional LSU_MISALIGN_CHECK_EN: fault misaligned H/W accesses instead of truncating the offset
module lsu #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input logic  clk_i,
  input logic  rst_i,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_RESP, RMW_WRITE} state_t;
  state_t state_q, state_d;
  logic [1:0]  off_q, off_in;
  logic [2:0]  size_q;
  logic [31:0] wd_q, addr_q, rd_q;
  logic [31:0] shifted, ext, mask, merged;
  logic [15:0] half;
  logic        bad_size, bad_range, misalign, fault, accept, word_in;
  assign word_in   = bus.core_size_i[1:0] == 2'b10;
  assign bad_size  = bus.core_size_i == 3'b011 || bus.core_size_i[2:1] == 2'b11;
  assign bad_range = bus.core_addr_i >= 32'(MEM_BYTES);
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign  = (bus.core_size_i[0] && bus.core_addr_i[0]) || (word_in && bus.core_addr_i[1:0] != 2'b00);
`else
  assign misalign  = 1'b0;
`endif
  // Offset normalised to the access size; in the checking build misaligned requests never use it
  assign off_in = word_in ? 2'b00 : bus.core_size_i[0] ? {bus.core_addr_i[1], 1'b0} : bus.core_addr_i[1:0];
  assign fault  = state_q == IDLE && bus.core_req_i && (bad_size || bad_range || misalign);
  assign accept = state_q == IDLE && bus.core_req_i && !fault;
  assign shifted = bus.mem_rd_i >> {off_q, 3'b000};
  assign half    = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
  assign ext     = size_q[1] ? bus.mem_rd_i
                 : size_q[0] ? {{16{~size_q[2] & half[15]}}, half}
                 : {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
  assign mask    = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
  assign merged  = (bus.mem_rd_i & ~mask) | ((wd_q << {off_q, 3'b000}) & mask);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q  <= off_in;
        size_q <= bus.core_size_i;
        wd_q   <= bus.core_wd_i;
        addr_q <= {bus.core_addr_i[31:2], 2'b00};
      end
      if (state_q == LOAD_RESP) rd_q <= ext;
    end
  end
  always_comb begin
    state_d          = state_q;
    bus.core_rd_o    = rd_q;
    bus.core_stall_o = 1'b0;
    bus.core_fault_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = state_q == IDLE ? {bus.core_addr_i[31:2], 2'b00} : addr_q;
    bus.mem_wd_o     = '0;
    if (state_q == IDLE) begin
      bus.core_fault_o = fault;
      if (accept) begin
        bus.mem_req_o = 1'b1;
        if (bus.core_we_i && word_in) begin
          bus.mem_we_o = 1'b1;
          bus.mem_wd_o = bus.core_wd_i;
        end else begin
          bus.core_stall_o = 1'b1;
          state_d          = bus.core_we_i ? RMW_WRITE : LOAD_RESP;
        end
      end
    end else if (state_q == LOAD_RESP) begin
      bus.core_rd_o = ext;
      state_d       = IDLE;
    end else begin
      bus.mem_req_o = 1'b1;
      bus.mem_we_o  = 1'b1;
      bus.mem_wd_o  = merged;
      state_d       = IDLE;
    end
    if (rst_i) begin
      bus.core_rd_o    = '0;
      bus.core_stall_o = 1'b0;
      bus.core_fault_o = 1'b0;
      bus.mem_req_o    = 1'b0;
      bus.mem_we_o     = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_wd_o     = '0;
    end
  end
endmodule
